// File: rtl/tart_emul_pkg.sv
// ============================================================================
//  Module      : tart_emul_pkg
//  Description : Shared constants and helpers for the antenna-signal emulator:
//                default geometry, LFSR polynomial/seed and jitter decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tart_emul_pkg;

    // Default geometry: 8 channels, 12x oversampling, 4-bit phase fields
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_RATIO = 12;
    localparam int DEFAULT_RBITS = 4;

    // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Two LFSR bits select the jitter: 01 -> +1, 10 -> -1, 00/11 -> 0
    function automatic logic signed [1:0] jitter_decode(input logic [1:0] bits);
        logic signed [1:0] j;
        case (bits)
            2'b01:   j = 2'sd1;
            2'b10:   j = -2'sd1;
            default: j = 2'sd0;
        endcase
        return j;
    endfunction

endpackage

`default_nettype wire

// File: rtl/emul_lfsr.sv
// ============================================================================
//  Module      : emul_lfsr
//  Description : 16-bit Galois LFSR that advances one step per step_i pulse.
//                Used only when the emulator is built with JITTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emul_lfsr #(
    parameter logic [15:0] POLY = 16'hB400,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next state: shift right, fold the polynomial back in when the LSB was 1
    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? POLY : 16'h0000);
        end
    end

    // State register, reset to the nonzero seed
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/signal_emulator.sv
// ============================================================================
//  Module      : signal_emulator
//  Description : Multi-channel antenna-signal emulator. Accepts one sample
//                word per RATIO oversampling cycles and drives each channel
//                with a programmable phase offset inside the period.
//                Optional macro JITTER_EN adds pseudo-random +/-1 cycle
//                jitter per channel from a 16-bit Galois LFSR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_emulator
    import tart_emul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int RATIO = DEFAULT_RATIO,
    parameter int RBITS = DEFAULT_RBITS
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [WIDTH*RBITS-1:0] offsets_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [WIDTH-1:0]       sig_o,
    output logic                   strobe_o,
    output logic                   underrun_o,
    input  logic                   ack_i
);

    // Last phase of a period; also the clamp value for offsets
    localparam logic [RBITS-1:0] C_LAST = RBITS'(RATIO - 1);

    logic [RBITS-1:0]            cnt_q,      cnt_d;
    logic [WIDTH-1:0]            cur_q,      cur_d;
    logic [WIDTH-1:0]            prv_q,      prv_d;
    logic [WIDTH-1:0]            sig_q,      sig_d;
    logic                        strobe_q,   strobe_d;
    logic                        underrun_q, underrun_d;
    logic [WIDTH-1:0][RBITS-1:0] off_q,      off_d;
    logic [WIDTH-1:0][RBITS-1:0] off_clamped;
    logic [WIDTH-1:0]            sig_sel;
    logic                        boundary;

    // A period boundary is the last phase while running
    assign boundary = enable_i && (cnt_q == C_LAST);
    assign ready_o  = boundary;

`ifdef JITTER_EN
    logic [15:0] lfsr_state;

    emul_lfsr #(
        .POLY (LFSR_POLY),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .step_i  (boundary),
        .state_o (lfsr_state)
    );
`endif

    // Per-channel offset clamp, jitter and old/new word selection
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [RBITS-1:0] field;
        logic [RBITS-1:0] eff;

        assign field          = offsets_i[i*RBITS +: RBITS];
        assign off_clamped[i] = (field > C_LAST) ? C_LAST : field;

`ifdef JITTER_EN
        localparam int JB = (2 * i) % 16;
        logic signed [1:0] jit;

        assign jit = jitter_decode(lfsr_state[JB +: 2]);

        // Apply the jitter step, saturating at both ends of the period
        always_comb begin
            eff = off_q[i];
            if (jit == 2'sd1 && off_q[i] != C_LAST) begin
                eff = off_q[i] + 1'b1;
            end else if (jit == -2'sd1 && off_q[i] != '0) begin
                eff = off_q[i] - 1'b1;
            end
        end
`else
        assign eff = off_q[i];
`endif

        // Before its offset a channel still shows the previous word
        assign sig_sel[i] = (cnt_q >= eff) ? cur_q[i] : prv_q[i];
    end

    // Next-state logic for counter, word pipeline, offsets and flags
    always_comb begin
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        prv_d      = prv_q;
        off_d      = off_q;
        underrun_d = underrun_q;
        strobe_d   = boundary;
        sig_d      = sig_sel;

        if (!enable_i) begin
            cnt_d = C_LAST;
            sig_d = cur_q;
        end else if (cnt_q == C_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (boundary) begin
            prv_d = cur_q;
            off_d = off_clamped;
            if (valid_i) begin
                cur_d = data_i;
            end
        end

        // A fresh underrun outranks a simultaneous acknowledge
        if (boundary && !valid_i) begin
            underrun_d = 1'b1;
        end else if (ack_i) begin
            underrun_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q      <= C_LAST;
            cur_q      <= '0;
            prv_q      <= '0;
            off_q      <= '0;
            sig_q      <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            prv_q      <= prv_d;
            off_q      <= off_d;
            sig_q      <= sig_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    assign sig_o      = sig_q;
    assign strobe_o   = strobe_q;
    assign underrun_o = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_signal_emulator.sv
// ============================================================================
//  Module      : tb_signal_emulator
//  Description : Directed self-checking bench for signal_emulator
//                (WIDTH=8, RATIO=12, RBITS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] offsets;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [7:0]  sig;
    logic        strobe;
    logic        underrun;
    logic        ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    signal_emulator #(
        .WIDTH (8),
        .RATIO (12),
        .RBITS (4)
    ) dut (
        .clock_i    (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .offsets_i  (offsets),
        .data_i     (data),
        .valid_i    (valid),
        .ready_o    (ready),
        .sig_o      (sig),
        .strobe_o   (strobe),
        .underrun_o (underrun),
        .ack_i      (ack)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the next edge is a period boundary (bounded)
    task automatic wait_boundary;
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_boundary: ready=%b expected 1 within 20 cycles", ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; valid = 1'b0; ack = 1'b0;
        data = 8'h00; offsets = 32'h0;
        repeat (3) tick();
        total++; if (sig !== 8'h00)    begin bad++; $display("FAIL reset_sig: got %h expected 00", sig); end
        total++; if (strobe !== 1'b0)  begin bad++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        total++; if (ready !== 1'b1)   begin bad++; $display("FAIL reset_ready_cnt_last: got %b expected 1", ready); end
        reset = 1'b0; enable = 1'b0;
        #1;
        total++; if (ready !== 1'b0)   begin bad++; $display("FAIL idle_ready: got %b expected 0", ready); end
    endtask

    task automatic test_offset0;
        offsets = 32'h0; data = 8'hA5; valid = 1'b1; enable = 1'b1;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL first_ready: got %b expected 1", ready); end
        tick();
        total++; if (strobe !== 1'b1) begin bad++; $display("FAIL o0_strobe0: got %b expected 1", strobe); end
        total++; if (sig !== 8'h00)   begin bad++; $display("FAIL o0_sig_e0: got %h expected 00", sig); end
        data = 8'h5A;
        tick();
        total++; if (sig !== 8'hA5)   begin bad++; $display("FAIL o0_sig_a5: got %h expected a5", sig); end
        total++; if (strobe !== 1'b0) begin bad++; $display("FAIL o0_strobe1: got %b expected 0", strobe); end
        for (int n = 2; n < 12; n++) begin
            tick();
            total++;
            if (strobe !== 1'b0 || sig !== 8'hA5) begin
                bad++;
                $display("FAIL o0_hold n=%0d: strobe=%b sig=%h expected 0/a5", n, strobe, sig);
            end
        end
        tick();
        total++; if (strobe !== 1'b1 || sig !== 8'hA5) begin bad++; $display("FAIL o0_period: strobe=%b sig=%h expected 1/a5", strobe, sig); end
        tick();
        total++; if (sig !== 8'h5A)   begin bad++; $display("FAIL o0_sig_5a: got %h expected 5a", sig); end
    endtask

    task automatic test_staggered;
        logic [8:0] tmp;
        offsets = 32'h76543210; data = 8'h00;
        wait_boundary();
        tick();
        data = 8'hFF;
        wait_boundary();
        tick();
        total++; if (sig !== 8'h00) begin bad++; $display("FAIL stag_e0: got %h expected 00", sig); end
        for (int k = 0; k < 8; k++) begin
            tick();
            tmp = (9'd1 << (k + 1)) - 9'd1;
            total++;
            if (sig !== tmp[7:0]) begin
                bad++;
                $display("FAIL stag_k%0d: got %h expected %h", k, sig, tmp[7:0]);
            end
        end
    endtask

    task automatic test_clamp;
        logic [7:0] exp;
        offsets = 32'h0000F000; data = 8'h00;
        wait_boundary();
        tick();
        data = 8'h08;
        wait_boundary();
        tick();
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp = (n == 12) ? 8'h08 : 8'h00;
            total++;
            if (sig !== exp) begin
                bad++;
                $display("FAIL clamp_n%0d: got %h expected %h", n, sig, exp);
            end
        end
    endtask

    task automatic test_underrun;
        offsets = 32'h0; valid = 1'b0; data = 8'hFF;
        wait_boundary();
        tick();
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set: got %b expected 1", underrun); end
        tick();
        total++; if (sig !== 8'h08) begin bad++; $display("FAIL ur_repeat: got %h expected 08", sig); end
        wait_boundary();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set_wins: got %b expected 1", underrun); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_ack: got %b expected 0", underrun); end
    endtask

    task automatic test_disable;
        offsets = 32'hBBBBBBBB; data = 8'h3C; valid = 1'b1;
        wait_boundary();
        tick();
        repeat (5) tick();
        total++; if (sig !== 8'h08) begin bad++; $display("FAIL dis_pre: got %h expected 08", sig); end
        enable = 1'b0;
        tick();
        total++; if (sig !== 8'h3C)   begin bad++; $display("FAIL dis_sig: got %h expected 3c", sig); end
        total++; if (strobe !== 1'b0) begin bad++; $display("FAIL dis_strobe: got %b expected 0", strobe); end
        total++; if (ready !== 1'b0)  begin bad++; $display("FAIL dis_ready: got %b expected 0", ready); end
        tick();
        total++; if (strobe !== 1'b0 || sig !== 8'h3C) begin bad++; $display("FAIL dis_idle: strobe=%b sig=%h expected 0/3c", strobe, sig); end
        offsets = 32'h0; data = 8'hC3; enable = 1'b1;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reen_ready: got %b expected 1", ready); end
        tick();
        total++; if (strobe !== 1'b1) begin bad++; $display("FAIL reen_strobe: got %b expected 1", strobe); end
        tick();
        total++; if (sig !== 8'hC3)   begin bad++; $display("FAIL reen_sig: got %h expected c3", sig); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reen_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_reset_mid;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++; if (sig !== 8'h00)   begin bad++; $display("FAIL rmid_sig: got %h expected 00", sig); end
        total++; if (strobe !== 1'b0) begin bad++; $display("FAIL rmid_strobe: got %b expected 0", strobe); end
        total++; if (ready !== 1'b1)  begin bad++; $display("FAIL rmid_ready: got %b expected 1", ready); end
        reset = 1'b0; enable = 1'b0;
    endtask

`ifdef JITTER_EN
    task automatic test_jitter;
        logic [15:0] s;
        logic [7:0]  oldv, newv, exp;
        int          k [8];
        logic [1:0]  b;
        logic        err;
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        offsets = 32'h66666666; valid = 1'b1;
        s = 16'hACE1;
        oldv = 8'h00;
        for (int p = 0; p < 1000; p++) begin
            newv = (p % 2 == 0) ? 8'hFF : 8'h00;
            data = newv; enable = 1'b1;
            tick();
            s = s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
            for (int i = 0; i < 8; i++) begin
                b = s[2*i +: 2];
                k[i] = (b == 2'b01) ? 7 : (b == 2'b10) ? 5 : 6;
            end
            err = 1'b0;
            for (int n = 0; n < 11; n++) begin
                tick();
                for (int i = 0; i < 8; i++) exp[i] = (n >= k[i]) ? newv[i] : oldv[i];
                if (sig !== exp) err = 1'b1;
            end
            total++;
            if (err) begin
                bad++;
                $display("FAIL jitter_p%0d: last sig=%h last expected=%h", p, sig, exp);
            end
            oldv = newv;
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef JITTER_EN
        test_jitter();
`else
        test_offset0();
        test_staggered();
        test_clamp();
        test_underrun();
        test_disable();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
